// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the receiver state encoding.
// The packager's hardcoded header uses DEFAULT_MAC as its destination.
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HUNT     = 3'd1,
    S_SFD_TAIL = 3'd2,
    S_HEADER   = 3'd3,
    S_PAYLOAD  = 3'd4,
    S_DROP     = 3'd5
  } eth_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [1:0]  SFD_HEAD_DIBIT = SFD_BYTE[7:6];
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] DEFAULT_MAC    = 48'hF00D_DEAD_BEEF;
  localparam int          HEADER_BYTES   = 14;

  // Byte idx of a MAC in wire order (idx 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
    return 8'(mac >> (8 * (5 - int'(idx))));
  endfunction

endpackage

// File: rtl/dibit_deserializer.sv
// Packs MSB-first dibits into bytes; byte_strobe marks the 4th dibit of a byte.
module dibit_deserializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] dibit,
  output logic [7:0] byte_o,
  output logic [1:0] dibit_cnt,
  output logic       byte_strobe
);

  logic [5:0] shift_q, shift_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (en) begin
      shift_d = {shift_q[3:0], dibit};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completed byte is visible combinationally in the cycle its last dibit arrives.
  assign byte_o      = {shift_q, dibit};
  assign dibit_cnt   = cnt_q;
  assign byte_strobe = en && !clr && (cnt_q == 2'd3);

endmodule

// File: rtl/ether_frame_receiver.sv
// Locks to the SFD in a dibit stream, filters on destination MAC, captures
// source MAC and ethertype, and emits payload bytes with end-of-frame status.
module ether_frame_receiver
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC      = DEFAULT_MAC,
  parameter int          PRE_MIN     = 16,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [7:0]  axiod,
  output logic [47:0] src_addr,
  output logic [15:0] ethertype,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        frame_err
);

  eth_state_e  state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d, pre_cur;
  logic [1:0]  sfd_cnt_q, sfd_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [10:0] len_cnt_q, len_cnt_d;
  logic        mac_ok_q, mac_ok_d, bc_ok_q, bc_ok_d;
  logic [47:0] src_sh_q, src_sh_d, src_addr_q, src_addr_d;
  logic [7:0]  type_sh_q, type_sh_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic        axiov_q, axiov_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [7:0]  axiod_q, axiod_d;
  logic [10:0] frame_len_q, frame_len_d;

  logic        in_frame, rx_strobe;
  logic [7:0]  rx_byte;
  logic [1:0]  dibit_cnt;

  assign in_frame = (state_q == S_HEADER) || (state_q == S_PAYLOAD);

  dibit_deserializer u_deser (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (!in_frame),
    .en          (axiiv && in_frame),
    .dibit       (axiid),
    .byte_o      (rx_byte),
    .dibit_cnt   (dibit_cnt),
    .byte_strobe (rx_strobe)
  );

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    sfd_cnt_d    = sfd_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    len_cnt_d    = len_cnt_q;
    mac_ok_d     = mac_ok_q;
    bc_ok_d      = bc_ok_q;
    src_sh_d     = src_sh_q;
    type_sh_d    = type_sh_q;
    src_addr_d   = src_addr_q;
    ethertype_d  = ethertype_q;
    axiov_d      = 1'b0;
    axiod_d      = axiod_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_err_d  = frame_err_q;
    // IDLE evaluates its first dibit exactly as HUNT would from an empty count.
    pre_cur      = (state_q == S_IDLE) ? 6'd0 : pre_cnt_q;

    case (state_q)
      S_IDLE, S_HUNT: begin
        if (!axiiv) begin
          state_d    = S_IDLE;
          pre_cnt_d  = '0;
          sfd_cnt_d  = '0;
          byte_cnt_d = '0;
          len_cnt_d  = '0;
        end else begin
          state_d = S_HUNT;
          if (axiid == PREAMBLE_DIBIT) begin
            pre_cnt_d = (pre_cur == 6'h3F) ? pre_cur : pre_cur + 6'd1;
          end else if (axiid == SFD_HEAD_DIBIT && int'(pre_cur) >= PRE_MIN) begin
            state_d   = S_SFD_TAIL;
            pre_cnt_d = '0;
            sfd_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
      end
      S_SFD_TAIL: begin
        if (!axiiv) begin
          state_d = S_IDLE;
        end else if (axiid == PREAMBLE_DIBIT) begin
          if (sfd_cnt_q == 2'd2) begin
            state_d    = S_HEADER;
            byte_cnt_d = '0;
            mac_ok_d   = 1'b1;
            bc_ok_d    = 1'b1;
          end else begin
            sfd_cnt_d = sfd_cnt_q + 2'd1;
          end
        end else begin
          state_d   = S_HUNT;
          pre_cnt_d = '0;
          sfd_cnt_d = '0;
        end
      end
      S_HEADER: begin
        if (!axiiv) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          frame_len_d  = '0;
          frame_err_d  = 1'b1;
        end else if (rx_strobe) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q < 4'd6) begin
            mac_ok_d = mac_ok_q && (rx_byte == mac_byte(MY_MAC, byte_cnt_q));
            bc_ok_d  = bc_ok_q && (rx_byte == mac_byte(BROADCAST_MAC, byte_cnt_q));
          end else if (byte_cnt_q < 4'd12) begin
            src_sh_d = {src_sh_q[39:0], rx_byte};
          end else begin
            type_sh_d = rx_byte;
          end
          if (byte_cnt_q == 4'(HEADER_BYTES - 1)) begin
            if (mac_ok_q || bc_ok_q) begin
              state_d     = S_PAYLOAD;
              len_cnt_d   = '0;
              src_addr_d  = src_sh_q;
              ethertype_d = {type_sh_q, rx_byte};
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!axiiv) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          frame_len_d  = len_cnt_q;
          frame_err_d  = (dibit_cnt != 2'd0);
        end else if (rx_strobe) begin
          if (len_cnt_q >= 11'(MAX_PAYLOAD)) begin
            state_d      = S_DROP;
            frame_done_d = 1'b1;
            frame_len_d  = 11'(MAX_PAYLOAD);
            frame_err_d  = 1'b1;
          end else begin
            axiov_d   = 1'b1;
            axiod_d   = rx_byte;
            len_cnt_d = len_cnt_q + 11'd1;
          end
        end
      end
      S_DROP: begin
        if (!axiiv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      sfd_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      len_cnt_q    <= '0;
      mac_ok_q     <= 1'b0;
      bc_ok_q      <= 1'b0;
      src_sh_q     <= '0;
      type_sh_q    <= '0;
      src_addr_q   <= '0;
      ethertype_q  <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      sfd_cnt_q    <= sfd_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      len_cnt_q    <= len_cnt_d;
      mac_ok_q     <= mac_ok_d;
      bc_ok_q      <= bc_ok_d;
      src_sh_q     <= src_sh_d;
      type_sh_q    <= type_sh_d;
      src_addr_q   <= src_addr_d;
      ethertype_q  <= ethertype_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign src_addr   = src_addr_q;
  assign ethertype  = ethertype_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ether_frame_receiver.sv
// Directed bench for ether_frame_receiver: dibit frames in, payload bytes and
// end-of-frame status collected by a monitor and checked against fixed values.
module tb_ether_frame_receiver;

  localparam logic [47:0] MY_MAC = 48'hF00D_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic        axiov;
  logic [7:0]  axiod;
  logic [47:0] src_addr;
  logic [15:0] ethertype;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  pay_q[$];
  int          done_cnt = 0;
  int          done_base;
  logic [10:0] last_len = '0;
  logic        last_err = 1'b0;
  int          overlap_cnt = 0;

  // Clock and reset
  always #5 clk = ~clk;

  ether_frame_receiver #(.MY_MAC(MY_MAC), .PRE_MIN(16), .MAX_PAYLOAD(1500)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .src_addr   (src_addr),
    .ethertype  (ethertype),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_err  (frame_err)
  );

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (axiov) rx_q.push_back(axiod);
      if (frame_done) begin
        done_cnt = done_cnt + 1;
        last_len = frame_len;
        last_err = frame_err;
      end
      if (axiov && frame_done) overlap_cnt = overlap_cnt + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_dibit(input logic [1:0] d);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_dibit(b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      axiiv = 1'b0;
      axiid = 2'b00;
    end
  endtask

  task automatic send_pre_sfd(input int pre_n);
    for (int i = 0; i < pre_n; i++) send_dibit(2'b01);
    send_byte(8'hD5);
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
    for (int i = 5; i >= 0; i--) send_byte(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) send_byte(src[8*i +: 8]);
    send_byte(et[15:8]);
    send_byte(et[7:0]);
  endtask

  task automatic send_frame(input int pre_n, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et);
    send_pre_sfd(pre_n);
    send_hdr(dst, src, et);
    for (int i = 0; i < pay_q.size(); i++) send_byte(pay_q[i]);
    idle(3);
  endtask

  task automatic start_test();
    rx_q.delete();
    pay_q.delete();
    done_base = done_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_axiov", 64'(axiov), 64'd0);
    chk("rst_axiod", 64'(axiod), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_len", 64'(frame_len), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_src", 64'(src_addr), 64'd0);
    chk("rst_type", 64'(ethertype), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame in packager format
    start_test();
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(28, MY_MAC, 48'h0123_4567_89AB, 16'h0800);
    chk("t1_nbytes", 64'(rx_q.size()), 64'd3);
    if (rx_q.size() == 3) begin
      chk("t1_b0", 64'(rx_q[0]), 64'h11);
      chk("t1_b1", 64'(rx_q[1]), 64'h22);
      chk("t1_b2", 64'(rx_q[2]), 64'h33);
    end
    chk("t1_done", 64'(done_cnt - done_base), 64'd1);
    chk("t1_len", 64'(last_len), 64'd3);
    chk("t1_err", 64'(last_err), 64'd0);
    chk("t1_src", 64'(src_addr), 64'h0123_4567_89AB);
    chk("t1_type", 64'(ethertype), 64'h0800);

    // Foreign destination is filtered silently
    start_test();
    for (int i = 0; i < 10; i++) pay_q.push_back(8'(8'h40 + i));
    send_frame(28, 48'h0A0B_0C0D_0E0F, 48'hAAAA_BBBB_CCCC, 16'h1234);
    chk("t2_nbytes", 64'(rx_q.size()), 64'd0);
    chk("t2_done", 64'(done_cnt - done_base), 64'd0);
    chk("t2_src", 64'(src_addr), 64'h0123_4567_89AB);
    chk("t2_type", 64'(ethertype), 64'h0800);

    // Short preamble does not lock; real frame after a 00 gap dibit does
    start_test();
    send_pre_sfd(8);
    send_dibit(2'b00);
    pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(20, MY_MAC, 48'h1122_3344_5566, 16'h86DD);
    chk("t3_nbytes", 64'(rx_q.size()), 64'd4);
    if (rx_q.size() == 4) begin
      chk("t3_b0", 64'(rx_q[0]), 64'hA1);
      chk("t3_b3", 64'(rx_q[3]), 64'hD4);
    end
    chk("t3_done", 64'(done_cnt - done_base), 64'd1);
    chk("t3_len", 64'(last_len), 64'd4);
    chk("t3_err", 64'(last_err), 64'd0);
    chk("t3_src", 64'(src_addr), 64'h1122_3344_5566);
    chk("t3_type", 64'(ethertype), 64'h86DD);

    // Broadcast frame truncated two dibits into byte six
    start_test();
    send_pre_sfd(28);
    send_hdr(48'hFFFF_FFFF_FFFF, 48'h0C0C_0D0D_0E0E, 16'h88B5);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i));
    send_dibit(2'b10);
    send_dibit(2'b01);
    idle(3);
    chk("t4_nbytes", 64'(rx_q.size()), 64'd5);
    if (rx_q.size() == 5) chk("t4_b4", 64'(rx_q[4]), 64'h64);
    chk("t4_done", 64'(done_cnt - done_base), 64'd1);
    chk("t4_len", 64'(last_len), 64'd5);
    chk("t4_err", 64'(last_err), 64'd1);
    chk("t4_src", 64'(src_addr), 64'h0C0C_0D0D_0E0E);
    chk("t4_type", 64'(ethertype), 64'h88B5);

    // Carrier lost inside the header
    start_test();
    send_pre_sfd(28);
    for (int i = 5; i >= 0; i--) send_byte(MY_MAC[8*i +: 8]);
    send_byte(8'h99);
    idle(3);
    chk("t5_done", 64'(done_cnt - done_base), 64'd1);
    chk("t5_len", 64'(last_len), 64'd0);
    chk("t5_err", 64'(last_err), 64'd1);
    chk("t5_nbytes", 64'(rx_q.size()), 64'd0);
    chk("t5_src", 64'(src_addr), 64'h0C0C_0D0D_0E0E);

    // Oversize payload of 1501 bytes
    start_test();
    for (int i = 0; i < 1501; i++) pay_q.push_back(8'(i));
    send_frame(28, MY_MAC, 48'h5555_6666_7777, 16'h0801);
    chk("t6_nbytes", 64'(rx_q.size()), 64'd1500);
    if (rx_q.size() == 1500) begin
      chk("t6_b0", 64'(rx_q[0]), 64'h00);
      chk("t6_b300", 64'(rx_q[300]), 64'h2C);
      chk("t6_b1499", 64'(rx_q[1499]), 64'hDB);
    end
    chk("t6_done", 64'(done_cnt - done_base), 64'd1);
    chk("t6_len", 64'(last_len), 64'd1500);
    chk("t6_err", 64'(last_err), 64'd1);

    // Following frame is accepted normally
    start_test();
    pay_q = '{8'h5A, 8'hA5};
    send_frame(28, MY_MAC, 48'hCAFE_0000_BABE, 16'h0806);
    chk("t7_nbytes", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) chk("t7_b1", 64'(rx_q[1]), 64'hA5);
    chk("t7_done", 64'(done_cnt - done_base), 64'd1);
    chk("t7_len", 64'(last_len), 64'd2);
    chk("t7_err", 64'(last_err), 64'd0);
    chk("t7_src", 64'(src_addr), 64'hCAFE_0000_BABE);

    // Reset mid-payload aborts without frame_done
    start_test();
    send_pre_sfd(28);
    send_hdr(MY_MAC, 48'h0A1B_2C3D_4E5F, 16'h0842);
    send_byte(8'h77);
    send_byte(8'h88);
    send_dibit(2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    axiiv = 1'b0;
    #1;
    chk("t8_axiod", 64'(axiod), 64'd0);
    chk("t8_src", 64'(src_addr), 64'd0);
    chk("t8_type", 64'(ethertype), 64'd0);
    chk("t8_len", 64'(frame_len), 64'd0);
    chk("t8_done", 64'(frame_done), 64'd0);
    chk("t8_err", 64'(frame_err), 64'd0);
    chk("t8_axiov", 64'(axiov), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("t8_nodone", 64'(done_cnt - done_base), 64'd0);

    start_test();
    pay_q = '{8'hE1, 8'hE2, 8'hE3};
    send_frame(16, MY_MAC, 48'h0F0E_0D0C_0B0A, 16'h9000);
    chk("t9_nbytes", 64'(rx_q.size()), 64'd3);
    if (rx_q.size() == 3) chk("t9_b2", 64'(rx_q[2]), 64'hE3);
    chk("t9_done", 64'(done_cnt - done_base), 64'd1);
    chk("t9_len", 64'(last_len), 64'd3);
    chk("t9_err", 64'(last_err), 64'd0);
    chk("t9_src", 64'(src_addr), 64'h0F0E_0D0C_0B0A);
    chk("t9_type", 64'(ethertype), 64'h9000);

    chk("no_overlap", 64'(overlap_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ether_frame_receiver.md
# ether_frame_receiver

Receive-side counterpart of the Ethernet packager. Consumes a continuous RMII-style dibit stream, MSB-first per byte (already un-reversed by the receive bitorder stage), in which each frame is preamble, SFD, 14-byte header, then payload. It locks to the SFD, filters on destination MAC, captures the source MAC and ethertype, and emits payload bytes one per valid pulse. It sits between the receive bitorder stage and the decoder's byte-input path.

## Interface
Parameters:
- MY_MAC, 48'hF00DDEADBEEF, accepted destination address (broadcast FF..FF also accepted)
- PRE_MIN, 16, minimum consecutive `01` preamble dibits required before SFD
- MAX_PAYLOAD, 1500, payload byte limit; exceeding it is an error

Ports:
- clk  in  1  single system clock; one clock domain, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- axiiv  in  1  dibit valid (carrier present)
- axiid  in  2  dibit, MSB-first within each byte
- axiov  out  1  one-cycle pulse, axiod holds a payload byte
- axiod  out  8  payload byte
- src_addr  out  48  source MAC of current/last accepted frame
- ethertype  out  16  ethertype of current/last accepted frame
- frame_done  out  1  one-cycle pulse at end of an accepted frame
- frame_len  out  11  payload byte count, valid with frame_done
- frame_err  out  1  valid with frame_done; 1 = truncated/misaligned/oversize

## Operation
- States: IDLE, HUNT, SFD_TAIL, HEADER, PAYLOAD, DROP.
- IDLE: on axiiv=1 go to HUNT, and evaluate that dibit as HUNT would.
- HUNT: pre_cnt counts consecutive `01` dibits (saturates at 63). Any `00`/`10` clears pre_cnt. Dibit `11` with pre_cnt >= PRE_MIN → SFD_TAIL, otherwise pre_cnt clears.
- SFD_TAIL: expects three `01` dibits (completes 0xD5). Any other dibit → HUNT with pre_cnt=0. Third `01` → HEADER, with byte_cnt=0 and dibit_cnt=0.
- HEADER: shift dibits into a byte, 4 dibits per byte, 14 bytes. Bytes 0-5 compare against MY_MAC/broadcast. Bytes 6-11 go to a shadow source reg and bytes 12-13 to a shadow ethertype reg. After byte 13: if matched, src_addr/ethertype update from shadows and state → PAYLOAD; otherwise → DROP.
- PAYLOAD: every 4th dibit assembles a byte; axiov pulses and len_cnt increments. When len_cnt would exceed MAX_PAYLOAD → DROP, with frame_done + frame_err pulse, frame_len=MAX_PAYLOAD.
- axiiv falling (first cycle axiiv=0):
  - in PAYLOAD: frame_done pulse, frame_len=len_cnt, frame_err=(dibit_cnt!=0); → IDLE
  - in HEADER: frame_done pulse, frame_len=0, frame_err=1; → IDLE. Filtered frames never report.
  - in HUNT/SFD_TAIL/DROP: → IDLE silently
- DROP: ignore dibits until axiiv=0.
- Reset: state IDLE; all counters 0; axiov, axiod, frame_done, frame_len, frame_err, src_addr, ethertype all 0. Reset mid-frame aborts without frame_done.

## Timing
- Byte latency: axiov asserts the cycle after the 4th dibit of that byte is sampled.
- Back-to-back frames require >= 1 cycle axiiv=0 between them; the frame_done cycle may coincide with the first preamble dibit of the next frame, and that dibit is evaluated in IDLE.
- frame_done asserts one cycle after axiiv falls. It never coincides with axiov, because the last byte pulse comes at least one cycle earlier.
- No back-pressure: the downstream consumer must accept one byte per 4 cycles.
- Counters: len_cnt 11 bits, byte_cnt 4 bits, dibit_cnt 2 bits (wraps 3→0 on byte completion).

## Structure
- Shared package eth_pkg holds:
  - the state enum
  - PREAMBLE_DIBIT=2'b01, SFD_BYTE=8'hD5, BROADCAST_MAC, HEADER_BYTES=14
  - the default MAC, which the packager's hardcoded header also uses
- One natural sub-module, dibit_deserializer: dibit shift register, dibit_cnt, byte_strobe; cleared by a sync clear from the FSM.

## Test plan
- Frame from the packager's format: 28×`01`, SFD, dest F00DDEADBEEF, src 0x0123456789AB, ethertype 0x0800, payload 0x11,0x22,0x33 → three axiov pulses with those bytes; src_addr/ethertype updated; frame_done with frame_len=3, frame_err=0.
- Dest 0x0A0B0C0D0E0F, 10-byte payload → no axiov, no frame_done, src_addr unchanged.
- Preamble of only 8×`01` then SFD → no lock; full frame following 20×`01` after a `00` gap dibit → accepted.
- axiiv drops after 2 dibits of a payload byte following 5 full bytes → frame_done, frame_len=5, frame_err=1.
- 1501-byte payload → 1500 axiov pulses, frame_done with frame_err=1, frame_len=1500; next frame accepted normally.
- rst_n asserted mid-payload → all outputs 0 immediately; after release the next frame is received correctly.
